dmem_arbiter: RTL
=================

# dmem_arbiter

Shares the single-port data memory (1024 x 32, synchronous read, 1-cycle latency) between the pipeline MEM stage and the debug/loader port. The pipeline has priority. A debug request is granted when the MEM stage is idle, or after a bounded wait, in which case the pipeline is stalled for one cycle. The block sits between the MEM-stage logic and the data-memory BRAM instance and drives all BRAM inputs.

## Interface
Parameters:
- `ADDR_W`, 10, word-address width into the BRAM
- `DATA_W`, 32, data width
- `MAX_WAIT`, 8, cycles a pending debug request may be denied before it is forced through; 0 means debug always wins

Ports:
- `clock`  in  1  single clock, rising edge
- `reset_n`  in  1  asynchronous, active-low reset
- `pipe_req`  in  1  MEM stage accesses memory this cycle (load or store)
- `pipe_we`  in  1  store; ignored unless `pipe_req`
- `pipe_addr`  in  ADDR_W  word address (ALU result bits [9:0])
- `pipe_wdata`  in  DATA_W  store data
- `pipe_rdata`  out  DATA_W  load data; equals `mem_dout`, valid the cycle after a granted read
- `pipe_stall`  out  1  MEM access not performed this cycle; upstream must hold and retry
- `dbg_req`  in  1  debug access request; held high until `dbg_ack`
- `dbg_we`, `dbg_addr`, `dbg_wdata`  in  1/ADDR_W/DATA_W  debug command; stable while `dbg_req` is high
- `dbg_ack`  out  1  one-cycle pulse: access complete
- `dbg_rdata`  out  DATA_W  registered read data, valid from the `dbg_ack` cycle until the next ack
- `mem_we`, `mem_addr`, `mem_din`  out  1/ADDR_W/DATA_W  BRAM port A inputs
- `mem_dout`  in  DATA_W  BRAM port A output

## Operation
- FSM states: `IDLE` and `DBG_RESP`.
- `IDLE`, debug not granted:
  - Memory port is driven by the pipeline.
  - `mem_we = pipe_req & pipe_we`; address and data come from the pipe inputs.
  - `pipe_stall = 0`.
- `IDLE`, debug granted:
  - Grant condition: `dbg_req & (!pipe_req | wait_cnt == MAX_WAIT)`.
  - Memory port is driven by the debug inputs.
  - `pipe_stall = pipe_req`.
  - Next state: `DBG_RESP`.
- `DBG_RESP`:
  - Register `mem_dout` into `dbg_rdata`. A debug write also registers it; the value is don't-care.
  - `dbg_ack = 1` for this cycle.
  - Memory port is driven by the pipeline, same as `IDLE` with no grant.
  - `dbg_req` is ignored in this cycle.
  - Next state: `IDLE`.
- `wait_cnt` (width `$clog2(MAX_WAIT+1)`, minimum 1):
  - Increments in `IDLE` while `dbg_req & pipe_req` and debug is not granted.
  - Saturates at `MAX_WAIT`.
  - Clears on grant or when `dbg_req` is low.
- `pipe_rdata` is always `mem_dout`. The cycle after a debug grant carries debug data. The pipeline stalled in the grant cycle, so it does not sample `pipe_rdata` in that cycle.
- Address widths are fixed; there is no byte-lane handling. Word address only.

## Timing
- Reset (`reset_n` low, asynchronous):
  - State `IDLE`, `wait_cnt = 0`, `dbg_ack = 0`, `dbg_rdata = 0`.
  - `mem_we` forced to 0 and `pipe_stall = 0` while reset is asserted.
- Pipeline access latency is 0 added cycles: the grant is combinational in the request cycle, and read data appears the next cycle.
- Debug access latency:
  - Pipeline idle: `dbg_ack` comes 1 cycle after `dbg_req` rises.
  - Pipeline busy every cycle: `dbg_ack` comes `MAX_WAIT + 1` cycles after `dbg_req` rises.
- Minimum debug issue rate is one access per 2 cycles. The requester samples `dbg_ack`, drops `dbg_req` or changes its command, and may re-request in the cycle after the ack.
- Reset during `DBG_RESP` aborts the access: no ack, and a write may or may not have landed. Reset during the grant cycle aborts likewise.
- Simultaneous `pipe_req` and `dbg_req` with `wait_cnt < MAX_WAIT`: the pipeline wins and `wait_cnt` increments.
- Simultaneous requests with `wait_cnt == MAX_WAIT`: debug wins, `pipe_stall = 1` for exactly one cycle, then the pipeline resumes in `DBG_RESP`.
- No two consecutive stall cycles are ever caused by one debug request.

## Structure
- Shared package `dmem_pkg`:
  - `ADDR_W` and `DATA_W` defaults
  - state enum `dmem_arb_state_t` {`IDLE`, `DBG_RESP`}
- Sub-module `dmem_starve_counter` holds the saturating `wait_cnt`.
  - Inputs: `inc`, `clr`.
  - Output: `at_max`.
  - Parameterised by `MAX_WAIT`.
- The FSM and port muxing remain in `dmem_arbiter`.
- The BRAM itself stays outside. Integration connects `mem_*` to the data-memory instance's `clka`, `wea`, `addra`, `dina` and `douta`.

## Test plan
- Reset, then idle: all outputs at their reset values; `mem_we` stays 0 while `reset_n` is low, even with `pipe_req = pipe_we = 1`.
- Pipeline store of `0xDEADBEEF` to address 5, then load from 5 → `pipe_rdata = 0xDEADBEEF` one cycle after the load; `pipe_stall` never asserts.
- Debug read of address 5 with the pipeline idle → `dbg_ack` 1 cycle after the request, `dbg_rdata = 0xDEADBEEF`; `dbg_rdata` holds after `dbg_req` drops.
- `pipe_req` held high continuously, debug write of `0x12345678` to address 9, `MAX_WAIT = 8` → write lands in cycle 8, `pipe_stall` high for exactly that one cycle, `dbg_ack` in cycle 9; a pipeline load of 9 afterwards returns `0x12345678`.
- `MAX_WAIT = 0`, simultaneous requests → debug granted immediately, `pipe_stall = 1` for one cycle; `dbg_req` held through the ack is not re-granted during `DBG_RESP`.
- `reset_n` pulsed low during `DBG_RESP` → no `dbg_ack`, state returns to `IDLE`, `dbg_rdata = 0`.

Source files
------------

// File: rtl/dmem_pkg.sv
`default_nettype none
// ============================================================================
// Module : dmem_pkg
// Desc   : Shared widths and arbiter state encoding for the data-memory port.
// Rev    : 1.0
// ============================================================================
package dmem_pkg;

  localparam int DMEM_ADDR_W = 10;
  localparam int DMEM_DATA_W = 32;

  localparam logic [0:0] ST_IDLE     = 1'b0;
  localparam logic [0:0] ST_DBG_RESP = 1'b1;

  typedef enum logic [0:0] {
    IDLE     = ST_IDLE,
    DBG_RESP = ST_DBG_RESP
  } dmem_arb_state_t;

endpackage
`default_nettype wire

// File: rtl/dmem_starve_counter.sv
`default_nettype none
// ============================================================================
// Module : dmem_starve_counter
// Desc   : Saturating count of cycles a pending debug request has been denied.
// Rev    : 1.0
// ============================================================================
module dmem_starve_counter
  import dmem_pkg::*;
#(
  parameter int MAX_WAIT = 8
) (
  input  logic clock,
  input  logic reset_n,
  input  logic inc,
  input  logic clr,
  output logic at_max
);

  localparam int CNT_W = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_WAIT);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // With MAX_WAIT = 0 the count is pinned at zero, so debug always wins.
  assign at_max = (cnt_q == CNT_MAX);

endmodule
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module : dmem_arbiter
// Desc   : Shares the single-port data BRAM between the MEM stage and debug.
// Rev    : 1.0
// ============================================================================
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int ADDR_W   = DMEM_ADDR_W,
  parameter int DATA_W   = DMEM_DATA_W,
  parameter int MAX_WAIT = 8
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              pipe_req,
  input  logic              pipe_we,
  input  logic [ADDR_W-1:0] pipe_addr,
  input  logic [DATA_W-1:0] pipe_wdata,
  output logic [DATA_W-1:0] pipe_rdata,
  output logic              pipe_stall,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_ack,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout
);

  dmem_arb_state_t   state_q;
  dmem_arb_state_t   state_d;
  logic [DATA_W-1:0] dbg_rdata_q;
  logic [DATA_W-1:0] dbg_rdata_d;
  logic              at_max;
  logic              in_idle;
  logic              grant;
  logic              wait_inc;
  logic              wait_clr;

  assign in_idle = (state_q == IDLE);
  // Gating with reset_n keeps the BRAM write enable quiet while reset is held.
  assign grant   = reset_n & in_idle & dbg_req & (~pipe_req | at_max);

  assign wait_inc = in_idle & dbg_req & pipe_req & ~grant;
  assign wait_clr = grant | ~dbg_req;

  dmem_starve_counter #(
    .MAX_WAIT (MAX_WAIT)
  ) u_starve (
    .clock   (clock),
    .reset_n (reset_n),
    .inc     (wait_inc),
    .clr     (wait_clr),
    .at_max  (at_max)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     state_d = grant ? DBG_RESP : IDLE;
      DBG_RESP: state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  assign dbg_rdata_d = (state_q == DBG_RESP) ? mem_dout : dbg_rdata_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      dbg_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      dbg_rdata_q <= dbg_rdata_d;
    end
  end

  always_comb begin
    mem_we   = reset_n & pipe_req & pipe_we;
    mem_addr = pipe_addr;
    mem_din  = pipe_wdata;
    if (grant) begin
      mem_we   = dbg_we;
      mem_addr = dbg_addr;
      mem_din  = dbg_wdata;
    end
  end

  assign pipe_stall = grant & pipe_req;
  assign pipe_rdata = mem_dout;
  assign dbg_ack    = (state_q == DBG_RESP);
  // Read data is forwarded in the ack cycle, then held by the register.
  assign dbg_rdata  = dbg_rdata_d;

endmodule
`default_nettype wire
